program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Holds the processor's current instruction address (PC).
- Selects the next PC each cycle from four sources: hold, sequential +4, PC-relative branch, absolute jump.
- Sits at the front of the fetch datapath. pc_out drives instruction memory; PC4 feeds the link/writeback path and branch adder.

Parameters:
- WIDTH, 64, address width in bits for pc_in, pc_out and PC4.
- RESET_VECTOR, 0, value loaded into the PC while reset is asserted.

Ports:
- clock  input  1  system clock; PC updates on rising edge.
- reset  input  1  asynchronous, active-high reset; forces PC to RESET_VECTOR.
- pc_in  input  WIDTH  branch offset (ps=10) or absolute target (ps=11).
- ps  input  2  PC source select.
- pc_out  output  WIDTH  current PC, registered.
- PC4  output  WIDTH  pc_out + 4, combinational.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Single WIDTH-bit register pc_q drives pc_out directly.
- Reset:
  - reset=1 forces pc_q = RESET_VECTOR immediately, without waiting for a clock edge.
  - pc_q stays at RESET_VECTOR while reset is high, regardless of ps and pc_in.
  - First update after release is at the first rising clock edge with reset=0.
- Next-PC select, sampled at the rising clock edge when reset=0:
  - ps=00 hold: pc_q <= pc_q.
  - ps=01 sequential: pc_q <= pc_q + 4.
  - ps=10 relative branch: pc_q <= pc_q + (pc_in << 2). pc_in is a signed word offset, two's complement; bits shifted out of the MSB are discarded.
  - ps=11 absolute jump: pc_q <= pc_in.
- Latency:
  - New PC is visible on pc_out one clock after ps/pc_in are sampled.
  - PC4 follows pc_out combinationally, in the same cycle.
- Arithmetic:
  - All adds are modulo 2^WIDTH; no carry-out or overflow flag.
  - Wrap-around: pc_q = 2^WIDTH-4 with ps=01 gives 0.
  - PC4 wraps the same way.
- ps is fully decoded; no illegal encodings.
- ps and pc_in are don't-care while reset is high.
- Reset asserted mid-cycle overrides any pending update. Reset deasserting coincident with a clock edge: the PC stays RESET_VECTOR for that edge; updates begin at the next edge.
- No X propagation from pc_in when ps is 00 or 01.

Optional Feature:
- Macro PC_ALIGN_EN.
- Defined:
  - Bits [1:0] of the next-PC value are forced to 0 for every ps selection, including the absolute jump.
  - Bits [1:0] of RESET_VECTOR are also forced to 0.
  - pc_out is therefore always word-aligned.
- Undefined:
  - No masking; the next PC is exactly as computed.
  - A misaligned pc_in on ps=11 propagates unchanged.

Test Plan:
- Reset hold: reset=1, ps cycled 00→01→10→11 over 4 clocks, pc_in=0x1234_5678_9ABC_DEF0 → pc_out=0 and PC4=4 on every cycle.
- Async reset: PC=0x100, raise reset between clock edges → pc_out=0 before the next rising edge.
- Sequential/hold: from reset, ps=01 for 3 clocks → pc_out 4, 8, 12 with PC4 8, 12, 16. Then ps=00 for 2 clocks → pc_out stays 12.
- Relative branch: PC=0x40, ps=10, pc_in=0xFFFF_FFFF_FFFF_FFFE (-2) → pc_out=0x38. From 0x38, pc_in=5 → pc_out=0x4C.
- Absolute jump and wrap: ps=11, pc_in=0xFFFF_FFFF_FFFF_FFFC → pc_out=0xFFFF_FFFF_FFFF_FFFC, PC4=0. Next ps=01 → pc_out=0.
- PC_ALIGN_EN: defined, ps=11, pc_in=0x1003 → pc_out=0x1000. Undefined, same stimulus → pc_out=0x1003.

Source files
------------

// File: rtl/program_counter.sv
// Program counter: holds the fetch address and selects hold / +4 / relative branch / absolute jump.
// Optional macro PC_ALIGN_EN forces the next PC and reset vector to word alignment.
module program_counter #(
    parameter int               WIDTH        = 64,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [1:0]       ps,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] PC4
);

    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

`ifdef PC_ALIGN_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
`else
    localparam logic [WIDTH-1:0] ALIGN_MASK = '1;
`endif

    localparam logic [WIDTH-1:0] RST_PC = RESET_VECTOR & ALIGN_MASK;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc4;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_sel;

    assign w_pc4 = r_pc + FOUR;

    // pc_in is only routed through the mux for ps[1]=1, so hold/sequential never see its X.
    always_comb begin
        w_sel = r_pc;
        case (ps)
            2'b00:   w_sel = r_pc;
            2'b01:   w_sel = w_pc4;
            2'b10:   w_sel = r_pc + {pc_in[WIDTH-3:0], 2'b00};
            2'b11:   w_sel = pc_in;
            default: w_sel = r_pc;
        endcase
    end

    assign w_next = w_sel & ALIGN_MASK;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_pc <= RST_PC;
        else
            r_pc <= w_next;
    end

    assign pc_out = r_pc;
    assign PC4    = w_pc4;

endmodule

// File: tb/tb_program_counter.sv
// Directed and randomized check of program_counter against an arithmetic reference model.
module tb_program_counter;

    localparam int W = 64;

    logic         clock;
    logic         reset;
    logic [W-1:0] pc_in;
    logic [1:0]   ps;
    logic [W-1:0] pc_out;
    logic [W-1:0] PC4;

    int n_cmp;
    int n_err;
    logic [W-1:0] mpc;

    program_counter #(.WIDTH(W), .RESET_VECTOR('0)) dut (
        .clock (clock),
        .reset (reset),
        .pc_in (pc_in),
        .ps    (ps),
        .pc_out(pc_out),
        .PC4   (PC4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [W-1:0] align(input logic [W-1:0] v);
`ifdef PC_ALIGN_EN
        return v - (v % 4);
`else
        return v;
`endif
    endfunction

    function automatic logic [W-1:0] model_next(input logic [W-1:0] pc, input logic [1:0] s,
                                                input logic [W-1:0] in);
        logic [W-1:0] n;
        if (s == 2'd0)      n = pc;
        else if (s == 2'd1) n = pc + 64'd4;
        else if (s == 2'd2) n = pc + in * 64'd4;
        else                n = in;
        return align(n);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] s, input logic [W-1:0] in, input string tag);
        ps    = s;
        pc_in = in;
        @(posedge clock);
        #1;
        mpc = model_next(mpc, s, in);
        chk({tag, "_pc"}, pc_out, mpc);
        chk({tag, "_pc4"}, PC4, mpc + 64'd4);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        #1;
        mpc = align(64'd0);
        chk({tag, "_async"}, pc_out, mpc);
        @(posedge clock);
        #1;
        chk({tag, "_held"}, pc_out, mpc);
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mpc   = '0;
        reset = 1'b1;
        ps    = 2'b00;
        pc_in = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_pc", pc_out, 64'd0);
        chk("reset_pc4", PC4, 64'd4);

        for (int i = 0; i < 4; i++) begin
            ps    = 2'(i);
            pc_in = 64'h1234_5678_9ABC_DEF0;
            @(posedge clock);
            #1;
            chk("rst_hold_pc", pc_out, 64'd0);
            chk("rst_hold_pc4", PC4, 64'd4);
        end
        reset = 1'b0;

        step(2'b01, '0, "seq1");
        chk("seq1_lit", pc_out, 64'd4);
        step(2'b01, '0, "seq2");
        chk("seq2_lit", pc_out, 64'd8);
        step(2'b01, '0, "seq3");
        chk("seq3_lit", PC4, 64'd16);
        step(2'b00, 64'hDEAD, "hold1");
        step(2'b00, 64'hBEEF, "hold2");
        chk("hold_lit", pc_out, 64'd12);

        step(2'b11, 64'h100, "jmp100");
        async_reset("arst");

        step(2'b11, 64'h40, "jmp40");
        step(2'b10, 64'hFFFF_FFFF_FFFF_FFFE, "br_neg");
        chk("br_neg_lit", pc_out, 64'h38);
        step(2'b10, 64'd5, "br_pos");
        chk("br_pos_lit", pc_out, 64'h4C);

        step(2'b11, 64'hFFFF_FFFF_FFFF_FFFC, "jmp_top");
        chk("wrap_pc4_lit", PC4, 64'd0);
        step(2'b01, '0, "wrap_seq");
        chk("wrap_seq_lit", pc_out, 64'd0);

        step(2'b11, 64'h1003, "jmp_misalign");
`ifdef PC_ALIGN_EN
        chk("align_lit", pc_out, 64'h1000);
`else
        chk("noalign_lit", pc_out, 64'h1003);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] rin;
            if ($urandom_range(0, 19) == 0) begin
                async_reset("rnd_rst");
            end else begin
                rin = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0)
                    rin = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                step(2'($urandom_range(0, 3)), rin, "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
